tone_dsm: RTL
=============

# tone_dsm

Parametrised single-voice tone source: a phase-accumulator NCO with a runtime tuning word, amplitude scaling, and click-free gating, feeding an internal first-order delta-sigma modulator that drives the 1-bit audio pin. It replaces the fixed-pitch divider/phase/sine/DSM chain at the top level. Pitch, amplitude and gate are loaded through a valid/ready command port, so a sequencer can play notes without resynthesis.

## Interface
- ACC_W, 24: phase accumulator width.
- LUT_AW, 8: phase bits used for sine lookup (top LUT_AW bits of phase); ≥3.
- PCM_W, 8: PCM sample width, unsigned offset-binary.
- AMP_W, 8: amplitude word width; amp = 2^AMP_W−1 is ≈full scale.
- DIV, 16: clocks per sample tick; ≥2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_freq  in  ACC_W  tuning word (phase increment per tick).
- cmd_amp  in  AMP_W  amplitude.
- cmd_gate  in  1  1 = note on, 0 = note off.
- sample_tick  out  1  one-clock pulse per sample period.
- active  out  1  voice in PLAYING or RELEASING.
- pcm  out  PCM_W  current sample (debug/monitor).
- y  out  1  delta-sigma bitstream.

## Operation
- Tick counter 0..DIV−1; sample_tick high when counter = DIV−1; wraps to 0.
- Command holding register, one deep. cmd_ready = !pending. Accept sets pending and latches freq/amp/gate. Pending command applied on next sample_tick edge, then pending cleared (cmd_ready high again the following cycle). Accept and apply in the same cycle never occur (ready low while pending).
- States: IDLE, PLAYING, RELEASING. Applied command:
  - gate=1 from IDLE → PLAYING, phase cleared to 0 on that tick (no increment that tick).
  - gate=1 from PLAYING/RELEASING → PLAYING, phase continues (no reset); new freq/amp take effect.
  - gate=0 from PLAYING → RELEASING; from IDLE → stays IDLE; freq/amp still latched.
- Non-apply ticks in PLAYING/RELEASING: phase ← phase + freq mod 2^ACC_W.
- RELEASING → IDLE on a tick where the addition carries out of ACC_W (phase wrap, sine at zero crossing), or immediately on that tick if freq = 0. On entry to IDLE phase ← 0.
- Sine: quarter-wave table, 2^(LUT_AW−2) entries, signed s = round((2^(PCM_W−1)−1)·sin(2π·idx/2^LUT_AW)); remaining quadrants by index mirroring and sign.
- Scaled: pcm = 2^(PCM_W−1) + ((s·amp) >>> AMP_W), arithmetic shift (floor); result always in range, no saturation needed. IDLE: pcm = 2^(PCM_W−1).
- DSM: register acc[PCM_W:0]; every clock acc ← {0, acc[PCM_W−1:0]} + pcm; y = acc[PCM_W].

## Timing
- Reset values: state IDLE, phase 0, tick counter 0, pending 0, cmd_ready 1, sample_tick 0, active 0, pcm 2^(PCM_W−1), acc 0, y 0.
- Reset mid-operation discards the pending command and state; no output glitch other than returning to reset values the edge after rst_n low is sampled.
- Phase/state update on the sample_tick edge; pcm registered one clock later; y reflects that pcm one further clock later (y valid 2 clocks after tick).
- active follows state, same edge as state change.
- cmd_valid may drop without acceptance; no data is latched then.

## Test plan
- Reset then idle, default params: pcm = 128 constant, y = 0,1,0,1… from the second clock after reset release; cmd_ready = 1, active = 0.
- ACC_W=8, LUT_AW=8, DIV=4: cmd gate=1, freq=1, amp=255 → PLAYING at next tick, pcm period = 256 ticks (1024 clocks), peak 127+128·255/256 → 254, trough 128−127 → 1 (floor rounding checked exactly).
- Back-to-back commands: second cmd_valid held while pending → cmd_ready low until the clock after the applying tick; both commands applied on consecutive ticks, in order.
- Note off mid-cycle (freq=1, phase=100): state RELEASING, active stays 1 until phase wraps 255→0 (156 ticks later), then IDLE, pcm = 128.
- Note off with freq=0: IDLE on the applying tick. Note on during RELEASING: PLAYING, phase not reset.
- amp = 0 while PLAYING → pcm = 128; DSM bit density over 256 clocks equals pcm/256 within ±1 for pcm = 1, 64, 200.

Source files
------------

// File: rtl/tone_dsm.sv
// Single-voice tone source: runtime-tuned phase-accumulator NCO with amplitude
// scaling and zero-crossing note release, feeding a first-order delta-sigma 1-bit output.
module tone_dsm #(
    parameter int ACC_W  = 24,
    parameter int LUT_AW = 8,
    parameter int PCM_W  = 8,
    parameter int AMP_W  = 8,
    parameter int DIV    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ACC_W-1:0] cmd_freq,
    input  logic [AMP_W-1:0] cmd_amp,
    input  logic             cmd_gate,
    output logic             sample_tick,
    output logic             active,
    output logic [PCM_W-1:0] pcm,
    output logic             y
);
    localparam int               CNT_W  = $clog2(DIV);
    localparam int               QN     = 2 ** (LUT_AW - 2);
    localparam int               PROD_W = PCM_W + AMP_W + 1;
    localparam logic [PCM_W-1:0] MID    = {1'b1, {(PCM_W-1){1'b0}}};
    localparam logic [PCM_W-2:0] PEAK   = '1;
    localparam real              PI     = 3.14159265358979323846;

    typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_RELEASING} state_e;

    function automatic logic [PCM_W-2:0] quarter_sine(input int k);
        real v;
        v = real'(PEAK) * $sin(2.0 * PI * real'(k) / real'(2 ** LUT_AW));
        return (PCM_W-1)'($rtoi(v + 0.5));
    endfunction

    // First quadrant only; the other three are folded onto it below.
    logic [PCM_W-2:0] qtab [QN];
    for (genvar k = 0; k < QN; k++) begin : g_qtab
        localparam logic [PCM_W-2:0] ENTRY = quarter_sine(k);
        assign qtab[k] = ENTRY;
    end

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             pending_q, pending_d;
    logic [ACC_W-1:0] pend_freq_q, pend_freq_d;
    logic [AMP_W-1:0] pend_amp_q, pend_amp_d;
    logic             pend_gate_q, pend_gate_d;
    logic [ACC_W-1:0] freq_q, freq_d;
    logic [AMP_W-1:0] amp_q, amp_d;
    state_e           state_q, state_d;
    logic [ACC_W-1:0] phase_q, phase_d;
    logic [PCM_W-1:0] pcm_q, pcm_d;
    logic [PCM_W:0]   acc_q, acc_d;

    logic [ACC_W:0]           phase_sum;
    logic [LUT_AW-1:0]        lut_idx;
    logic [LUT_AW-3:0]        lut_k, lut_k_mir;
    logic [PCM_W-2:0]         sine_mag;
    logic signed [PCM_W-1:0]  sine_val;
    logic signed [PROD_W-1:0] prod;

    assign sample_tick = (tick_cnt_q == CNT_W'(DIV - 1));
    assign cmd_ready   = !pending_q;
    assign active      = (state_q != S_IDLE);
    assign pcm         = pcm_q;
    assign y           = acc_q[PCM_W];

    // NOTE: every signal written in an always_comb gets a default first, so no path can hold a stale value and infer a latch.
    always_comb begin
        tick_cnt_d  = sample_tick ? '0 : tick_cnt_q + CNT_W'(1);
        pending_d   = pending_q;
        pend_freq_d = pend_freq_q;
        pend_amp_d  = pend_amp_q;
        pend_gate_d = pend_gate_q;
        if (cmd_valid && !pending_q) begin
            pending_d   = 1'b1;
            pend_freq_d = cmd_freq;
            pend_amp_d  = cmd_amp;
            pend_gate_d = cmd_gate;
        end else if (sample_tick && pending_q) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        freq_d    = freq_q;
        amp_d     = amp_q;
        state_d   = state_q;
        phase_d   = phase_q;
        phase_sum = {1'b0, phase_q} + {1'b0, freq_q};
        if (sample_tick && pending_q) begin
            freq_d = pend_freq_q;
            amp_d  = pend_amp_q;
            if (pend_gate_q) begin
                state_d = S_PLAYING;
                if (state_q == S_IDLE) phase_d = '0;
            end else if (state_q != S_IDLE) begin
                if (pend_freq_q == '0) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else begin
                    state_d = S_RELEASING;
                end
            end
        end else if (sample_tick) begin
            unique case (state_q)
                S_PLAYING: phase_d = phase_sum[ACC_W-1:0];
                S_RELEASING: begin
                    // Carry out of the accumulator marks a zero crossing: stop there.
                    if (phase_sum[ACC_W] || freq_q == '0) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_sum[ACC_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lut_idx   = phase_q[ACC_W-1 -: LUT_AW];
        lut_k     = lut_idx[LUT_AW-3:0];
        lut_k_mir = '0 - lut_k;
        sine_mag  = qtab[lut_k];
        if (lut_idx[LUT_AW-2]) sine_mag = (lut_k == '0) ? PEAK : qtab[lut_k_mir];
        sine_val  = lut_idx[LUT_AW-1] ? -$signed({1'b0, sine_mag}) : $signed({1'b0, sine_mag});
        prod      = PROD_W'(sine_val) * PROD_W'($signed({1'b0, amp_q}));
        pcm_d     = (state_q == S_IDLE) ? MID : MID + PCM_W'(prod >>> AMP_W);
        acc_d     = {1'b0, acc_q[PCM_W-1:0]} + {1'b0, pcm_q};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the sine table is constant logic, not storage, so only real flops appear in this reset branch.
            tick_cnt_q  <= '0;
            pending_q   <= 1'b0;
            pend_freq_q <= '0;
            pend_amp_q  <= '0;
            pend_gate_q <= 1'b0;
            freq_q      <= '0;
            amp_q       <= '0;
            state_q     <= S_IDLE;
            phase_q     <= '0;
            pcm_q       <= MID;
            acc_q       <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            pending_q   <= pending_d;
            pend_freq_q <= pend_freq_d;
            pend_amp_q  <= pend_amp_d;
            pend_gate_q <= pend_gate_d;
            freq_q      <= freq_d;
            amp_q       <= amp_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            pcm_q       <= pcm_d;
            acc_q       <= acc_d;
        end
    end
endmodule
